hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle unit handshake with
// watchdog, and branch flush sequencing for a 5-stage in-order pipeline.
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | normal issue; load-use and mcStart are acted on here
// MC_WAIT | decode held while the multi-cycle unit works; watchdog counts
// FLUSH   | extra flush cycles after a taken branch (FLUSH_CYCLES > 1)
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned WD_LIMIT     = 63
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        deMemToRead_i,
  input  logic [4:0]  deRtAddr_i,
  input  logic [4:0]  ifRsAddr_i,
  input  logic [4:0]  ifRtAddr_i,
  input  logic        ifUsesRt_i,
  input  logic        branchTaken_i,
  input  logic        mcStart_i,
  input  logic        mcDone_i,
  output logic        pcWrite_o,
  output logic        fdWrite_o,
  output logic        fdFlush_o,
  output logic        deFlush_o,
  output logic        mcGo_o,
  output logic [1:0]  state_o,
  output logic [15:0] stallCnt_o,
  output logic        wdErr_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  // The branch cycle itself is the first flush cycle, so FLUSH holds for
  // FLUSH_CYCLES-1 cycles; the down-counter is loaded with one less than that.
  localparam logic [2:0] FL_LOAD = 3'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
  localparam state_t     BR_NEXT = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
  localparam logic [7:0] WD_TC   = 8'(WD_LIMIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_flush_cnt;
  logic [2:0]  w_flush_cnt_nxt;
  logic [7:0]  r_wd_cnt;
  logic [7:0]  w_wd_cnt_nxt;
  logic [15:0] r_stall_cnt;
  logic        r_wd_err;
  logic        w_wd_err_set;
  logic        w_load_use;
  logic        w_pc_write;
  logic        w_fd_write;
  logic        w_fd_flush;
  logic        w_de_flush;
  logic        w_mc_go;

  assign w_load_use = deMemToRead_i && (deRtAddr_i != 5'd0) &&
                      ((deRtAddr_i == ifRsAddr_i) ||
                       (ifUsesRt_i && (deRtAddr_i == ifRtAddr_i)));

  always_comb begin
    w_pc_write      = 1'b1;
    w_fd_write      = 1'b1;
    w_fd_flush      = 1'b0;
    w_de_flush      = 1'b0;
    w_mc_go         = 1'b0;
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_wd_cnt_nxt    = r_wd_cnt;
    w_wd_err_set    = 1'b0;

    if (branchTaken_i) begin
      w_fd_flush      = 1'b1;
      w_de_flush      = 1'b1;
      w_state_nxt     = BR_NEXT;
      w_flush_cnt_nxt = FL_LOAD;
      w_wd_cnt_nxt    = 8'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_load_use) begin
            w_pc_write = 1'b0;
            w_fd_write = 1'b0;
            w_de_flush = 1'b1;
          end else if (mcStart_i) begin
            w_mc_go      = 1'b1;
            w_pc_write   = 1'b0;
            w_fd_write   = 1'b0;
            w_de_flush   = 1'b1;
            w_state_nxt  = ST_MC_WAIT;
            w_wd_cnt_nxt = 8'd0;
          end
        end
        ST_MC_WAIT: begin
          if (mcDone_i) begin
            w_state_nxt  = ST_RUN;
            w_wd_cnt_nxt = 8'd0;
          end else begin
            w_pc_write = 1'b0;
            w_fd_write = 1'b0;
            w_de_flush = 1'b1;
            if (r_wd_cnt == WD_TC) begin
              w_wd_err_set = 1'b1;
              w_state_nxt  = ST_RUN;
              w_wd_cnt_nxt = 8'd0;
            end else begin
              w_wd_cnt_nxt = r_wd_cnt + 8'd1;
            end
          end
        end
        ST_FLUSH: begin
          w_fd_flush = 1'b1;
          w_de_flush = 1'b1;
          if (r_flush_cnt == 3'd0) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 3'd1;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end

    // Reset acts on the outputs immediately, not just on the next edge.
    if (!rst_ni) begin
      w_pc_write = 1'b0;
      w_fd_write = 1'b0;
      w_fd_flush = 1'b1;
      w_de_flush = 1'b1;
      w_mc_go    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 3'd0;
      r_wd_cnt    <= 8'd0;
      r_stall_cnt <= 16'd0;
      r_wd_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_wd_cnt    <= w_wd_cnt_nxt;
      if (!w_pc_write && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_wd_err_set) begin
        r_wd_err <= 1'b1;
      end
    end
  end

  assign pcWrite_o  = w_pc_write;
  assign fdWrite_o  = w_fd_write;
  assign fdFlush_o  = w_fd_flush;
  assign deFlush_o  = w_de_flush;
  assign mcGo_o     = w_mc_go;
  assign state_o    = r_state;
  assign stallCnt_o = r_stall_cnt;
  assign wdErr_o    = r_wd_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected per-cycle outputs
// from a behavioural model; a monitor pops and compares them mid-cycle.
module tb_hazard_ctrl;

  localparam int FLC = 3;
  localparam int WDL = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        deMemToRead_i = 1'b0;
  logic [4:0]  deRtAddr_i = '0;
  logic [4:0]  ifRsAddr_i = '0;
  logic [4:0]  ifRtAddr_i = '0;
  logic        ifUsesRt_i = 1'b0;
  logic        branchTaken_i = 1'b0;
  logic        mcStart_i = 1'b0;
  logic        mcDone_i = 1'b0;
  logic        pcWrite_o, fdWrite_o, fdFlush_o, deFlush_o, mcGo_o, wdErr_o;
  logic [1:0]  state_o;
  logic [15:0] stallCnt_o;

  hazard_ctrl #(.FLUSH_CYCLES(FLC), .WD_LIMIT(WDL)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .deMemToRead_i(deMemToRead_i), .deRtAddr_i(deRtAddr_i),
    .ifRsAddr_i(ifRsAddr_i), .ifRtAddr_i(ifRtAddr_i), .ifUsesRt_i(ifUsesRt_i),
    .branchTaken_i(branchTaken_i), .mcStart_i(mcStart_i), .mcDone_i(mcDone_i),
    .pcWrite_o(pcWrite_o), .fdWrite_o(fdWrite_o), .fdFlush_o(fdFlush_o),
    .deFlush_o(deFlush_o), .mcGo_o(mcGo_o), .state_o(state_o),
    .stallCnt_o(stallCnt_o), .wdErr_o(wdErr_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pc, fd, fdf, def, go;
    logic [1:0]  st;
    logic [15:0] stall;
    logic        wde;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_cycle = 0;

  // Behavioural model: what the pipeline is doing, in plain terms.
  bit m_in_mc;
  int m_mc_elapsed;
  int m_flush_left;
  int m_stalls;
  bit m_wderr;

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, n_cycle, act, exp_v);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pcWrite",  int'(pcWrite_o),  int'(e.pc));
        chk("fdWrite",  int'(fdWrite_o),  int'(e.fd));
        chk("fdFlush",  int'(fdFlush_o),  int'(e.fdf));
        chk("deFlush",  int'(deFlush_o),  int'(e.def));
        chk("mcGo",     int'(mcGo_o),     int'(e.go));
        chk("state",    int'(state_o),    int'(e.st));
        chk("stallCnt", int'(stallCnt_o), int'(e.stall));
        chk("wdErr",    int'(wdErr_o),    int'(e.wde));
        n_cycle++;
      end
    end
  end

  task automatic cyc(input bit rst, input bit br, input bit mem, input logic [4:0] drt,
                     input logic [4:0] rs, input logic [4:0] rt, input bit uses,
                     input bit mcs, input bit done);
    exp_t e;
    bit   hit;
    @(negedge clk);
    rst_ni = !rst; branchTaken_i = br; deMemToRead_i = mem; deRtAddr_i = drt;
    ifRsAddr_i = rs; ifRtAddr_i = rt; ifUsesRt_i = uses; mcStart_i = mcs; mcDone_i = done;
    if (rst) begin
      e = '{pc: 1'b0, fd: 1'b0, fdf: 1'b1, def: 1'b1, go: 1'b0, st: 2'd0, stall: 16'd0, wde: 1'b0};
      m_in_mc = 0; m_mc_elapsed = 0; m_flush_left = 0; m_stalls = 0; m_wderr = 0;
      sb.push_back(e);
      return;
    end
    e.st    = m_in_mc ? 2'd1 : ((m_flush_left > 0) ? 2'd2 : 2'd0);
    e.stall = 16'(m_stalls);
    e.wde   = m_wderr;
    hit = mem && (drt != 0) && ((drt == rs) || (uses && drt == rt));
    {e.pc, e.fd, e.fdf, e.def, e.go} = 5'b11000;
    if (br) begin
      {e.pc, e.fd, e.fdf, e.def, e.go} = 5'b11110;
      m_in_mc = 0;
      m_flush_left = FLC - 1;
    end else if (m_in_mc) begin
      if (done) m_in_mc = 0;
      else begin
        {e.pc, e.fd, e.fdf, e.def, e.go} = 5'b00010;
        m_mc_elapsed++;
        if (m_mc_elapsed == WDL) begin
          m_wderr = 1;
          m_in_mc = 0;
        end
      end
    end else if (m_flush_left > 0) begin
      {e.pc, e.fd, e.fdf, e.def, e.go} = 5'b11110;
      m_flush_left--;
    end else if (hit) begin
      {e.pc, e.fd, e.fdf, e.def, e.go} = 5'b00010;
    end else if (mcs) begin
      {e.pc, e.fd, e.fdf, e.def, e.go} = 5'b00011;
      m_in_mc = 1;
      m_mc_elapsed = 0;
    end
    if (!e.pc && m_stalls < 65535) m_stalls++;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : stim
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load-use on rs
    cyc(0, 0, 1, 5'd8, 5'd8, 5'd1, 0, 0, 0);
    idle(1);
    // no false stalls: r0 destination, rt match without rt use
    cyc(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    cyc(0, 0, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0);
    // rt match with rt use does stall
    cyc(0, 0, 1, 5'd9, 5'd3, 5'd9, 1, 0, 0);
    idle(1);
    // multi-cycle op completing
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(4);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // mcDone outside MC_WAIT is ignored
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // watchdog timeout, flag sticks
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(8);
    // branch with simultaneous load-use and mcStart
    cyc(0, 1, 1, 5'd4, 5'd4, 5'd0, 0, 1, 0);
    idle(4);
    // branch restarting an ongoing flush, then branch out of MC_WAIT
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // reset mid-MC_WAIT
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 1) == 1),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 4) == 0));
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
